t_pulse_debouncer: RTL and testbench
====================================

# t_pulse_debouncer

Upstream stage of the T flip-flop: converts a raw, bouncing, asynchronous push-button input into a clean single-cycle toggle-enable pulse `t`. Each qualified press yields exactly one `t` pulse, so the downstream T flip-flop toggles `q` exactly once per press. The block contains:

- a synchronizer chain,
- a four-state debounce FSM with a qualification counter,
- a registered rising-edge pulse output.

## Interface

Parameters:

- `SYNC_STAGES`, default 2: number of synchronizer flops on `btn`. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles (D) required to accept a level change. Must be ≥ 1.

Ports:

- `clk`  input  1  single system clock; all state on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high. Clears all state immediately.
- `btn`  input  1  raw button level, asynchronous to `clk`, may bounce.
- `t`  output  1  registered one-cycle pulse on each debounced press; connects directly to the T flip-flop `t` input.
- `btn_stable`  output  1  registered debounced button level.
- `busy`  output  1  registered; high while a level change is being qualified.

## Operation

- **Synchronizer.** `btn` passes through `SYNC_STAGES` flops. Call the last flop output `sync_btn`. The FSM sees only `sync_btn`.
- **Counter.** Width is clog2(DEBOUNCE_CYCLES+1). It never exceeds D. It is cleared on every state change that is not a count step.
- **FSM states and transitions:**
  - IDLE_LOW.
    - `sync_btn`=1 → CNT_HIGH, cnt=1.
  - CNT_HIGH.
    - `sync_btn`=0 → IDLE_LOW, cnt=0. The bounce is rejected and no pulse is produced.
    - `sync_btn`=1 and cnt==D → STABLE_HIGH, cnt=0, `t`=1 for the next cycle.
    - Otherwise cnt+1.
  - STABLE_HIGH.
    - `sync_btn`=0 → CNT_LOW, cnt=1.
  - CNT_LOW.
    - `sync_btn`=1 → STABLE_HIGH, cnt=0. No pulse is produced.
    - `sync_btn`=0 and cnt==D → IDLE_LOW, cnt=0.
    - Otherwise cnt+1.
- **Outputs:**
  - `btn_stable` = 1 in STABLE_HIGH and CNT_LOW.
  - `busy` = 1 in CNT_HIGH and CNT_LOW.
  - `t` is high only in the single cycle after the CNT_HIGH→STABLE_HIGH transition.
- **Release.** Releasing the button never produces a pulse. Holding the button indefinitely produces exactly one pulse.
- **Reset values.** `t`=0, `btn_stable`=0, `busy`=0, state=IDLE_LOW, cnt=0, all synchronizer flops=0.
- **Reset mid-operation.** Any in-progress qualification and any pending pulse are discarded. After reset release the block re-qualifies from IDLE_LOW. If the button is held through reset, one pulse is produced after the full latency.

## Timing

- **Press latency.** Let `btn` go 1 and be stable from before edge X. Then:
  - `sync_btn` is 1 from edge X+SYNC_STAGES-1 onward.
  - The FSM enters CNT_HIGH at edge X+SYNC_STAGES.
  - `t`=1 between edges X+SYNC_STAGES+D and X+SYNC_STAGES+D+1.
  - With the defaults, `t` is high in the cycle after edge X+6.
- **Qualification window.** `sync_btn` must be 1 at D+1 consecutive edges, i.e. the entry edge plus D count edges. A single 0 sample resets qualification.
- **Release latency.** `btn_stable` falls at edge Y+SYNC_STAGES+D for a release stable from before edge Y.
- **Pulse spacing.** Minimum spacing between two `t` pulses is 2·(D+1) cycles: one full low qualification plus one full high qualification.
- **Simultaneous events.** If reset assertion coincides with a `t` cycle, `t` drops immediately.
- **Glitch-free outputs.** All outputs come straight from flops, with no combinational path from `btn`.

## Structure

- **Shared package `debounce_pkg`:**
  - 2-bit state encoding constants: IDLE_LOW=0, CNT_HIGH=1, STABLE_HIGH=2, CNT_LOW=3.
  - Default values for `SYNC_STAGES` and `DEBOUNCE_CYCLES`.
- **Sub-module `btn_synchronizer`:**
  - Parameterized by `SYNC_STAGES`, with ports `clk`, `rst`, `d`, `q`.
  - Reused for any other asynchronous inputs in the codebase.
- **Top-level contents.** FSM, counter and output registers. The T flip-flop is not included; it is instantiated alongside this block at the integration level.

## Test plan

All scenarios use default parameters unless noted.

1. **Clean press.** `btn` 0→1 held 20 cycles → exactly one `t` pulse, high for 1 cycle, in the cycle after edge X+6. `btn_stable` is 1 from the same edge. `busy` is high for 4 cycles before that.
2. **Short bounce.** `btn` toggles 1,0,1,0 with each level held 2 cycles, then stays 0 → `t` never asserts, `btn_stable` stays 0, `busy` pulses and returns to 0.
3. **Bouncy press and release.** 3 bounces shorter than D, then held high 10 cycles, then release with 3 bounces → exactly one `t` pulse. No pulse on release. `btn_stable` returns to 0 D+SYNC_STAGES edges after the final low.
4. **Reset mid-qualification.** `rst` asserted during CNT_HIGH → `t`, `busy` and `btn_stable` drop to 0 immediately. With `btn` held high through reset release, one pulse occurs 6 edges after release.
5. **Integration with the T flip-flop.** Three separated clean presses → `q` toggles 0→1→0→1, with each toggle one cycle after its `t` pulse.
6. **DEBOUNCE_CYCLES=1.** A 2-cycle-wide `sync_btn` high window → one pulse. A 1-cycle-wide window → no pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debounce path: FSM state encoding
// and default parameter values.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'd0,
    CNT_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    CNT_LOW     = 2'd3
  } db_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/btn_synchronizer.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Shared by every asynchronous level input in the codebase.
module btn_synchronizer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d};
  end

  assign q = sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/t_pulse_debouncer.sv
// Debounces a raw push-button and emits one single-cycle toggle-enable pulse
// per qualified press, for the downstream T flip-flop.
module t_pulse_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic t,
  output logic btn_stable,
  output logic busy
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync_btn;
  db_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pulse_nxt;

  btn_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (sync_btn)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE_LOW: begin
        cnt_nxt = '0;
        if (sync_btn) begin
          state_nxt = CNT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      CNT_HIGH: begin
        if (!sync_btn) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        cnt_nxt = '0;
        if (!sync_btn) begin
          state_nxt = CNT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      CNT_LOW: begin
        if (sync_btn) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Only a completed high qualification fires; a bounce back from CNT_LOW does not.
  assign pulse_nxt = (state == CNT_HIGH) && (state_nxt == STABLE_HIGH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are registered from the next-state decode so they track state with no comb path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t          <= 1'b0;
      btn_stable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      t          <= pulse_nxt;
      btn_stable <= (state_nxt == STABLE_HIGH) || (state_nxt == CNT_LOW);
      busy       <= (state_nxt == CNT_HIGH) || (state_nxt == CNT_LOW);
    end
  end

endmodule

// File: tb/tb_t_pulse_debouncer.sv
// Directed bench for t_pulse_debouncer: default instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_t_pulse_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic btn1 = 1'b0;
  logic t, btn_stable, busy;
  logic t1, btn_stable1, busy1;
  logic q;

  int total = 0;
  int bad   = 0;
  int npulse = 0;
  int npulse1 = 0;

  always #5 clk = ~clk;

  t_pulse_debouncer dut (
    .clk(clk), .rst(rst), .btn(btn),
    .t(t), .btn_stable(btn_stable), .busy(busy)
  );

  t_pulse_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .btn(btn1),
    .t(t1), .btn_stable(btn_stable1), .busy(busy1)
  );

  // Downstream T flip-flop as used at integration level
  always_ff @(posedge clk or posedge rst) begin
    if (rst)    q <= 1'b0;
    else if (t) q <= ~q;
  end

  always @(negedge clk) begin
    if (t)  npulse++;
    if (t1) npulse1++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; btn = 1'b0; btn1 = 1'b0;
    step(2);
    total++;
    if ({t, btn_stable, busy} !== 3'b000) begin
      bad++; $display("FAIL reset_outputs got=%b exp=000", {t, btn_stable, busy});
    end
    rst = 1'b0;
    step(3);
    total++;
    if ({t, btn_stable, busy, q} !== 4'b0000) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=0000", {t, btn_stable, busy, q});
    end
  endtask

  task automatic test_clean_press;
    int p0;
    p0 = npulse;
    btn = 1'b1;
    step(2); // X+1
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL clean_busy_x1 got=%b exp=0", busy); end
    step(1); // X+2
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL clean_busy_x2 got=%b exp=1", busy); end
    step(3); // X+5
    total++;
    if ({t, btn_stable, busy} !== 3'b001) begin
      bad++; $display("FAIL clean_x5 got=%b exp=001", {t, btn_stable, busy});
    end
    step(1); // X+6
    total++;
    if ({t, btn_stable, busy} !== 3'b110) begin
      bad++; $display("FAIL clean_x6 got=%b exp=110", {t, btn_stable, busy});
    end
    step(1); // X+7
    total++;
    if ({t, btn_stable} !== 2'b01) begin
      bad++; $display("FAIL clean_x7 got=%b exp=01", {t, btn_stable});
    end
    step(13);
    btn = 1'b0;
    step(10);
    total++;
    if (npulse - p0 !== 1) begin bad++; $display("FAIL clean_pulse_count got=%0d exp=1", npulse - p0); end
    total++;
    if ({btn_stable, busy} !== 2'b00) begin
      bad++; $display("FAIL clean_released got=%b exp=00", {btn_stable, busy});
    end
  endtask

  task automatic test_short_bounce;
    int p0;
    logic busy_seen, stable_seen;
    logic [7:0] pat;
    p0 = npulse; busy_seen = 1'b0; stable_seen = 1'b0;
    pat = 8'b00110011;
    for (int i = 0; i < 8; i++) begin
      btn = pat[i];
      step(1);
      busy_seen   |= busy;
      stable_seen |= btn_stable;
    end
    btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      busy_seen   |= busy;
      stable_seen |= btn_stable;
    end
    total++;
    if (npulse - p0 !== 0) begin bad++; $display("FAIL bounce_no_pulse got=%0d exp=0", npulse - p0); end
    total++;
    if (stable_seen !== 1'b0) begin bad++; $display("FAIL bounce_stable got=%b exp=0", stable_seen); end
    total++;
    if (busy_seen !== 1'b1) begin bad++; $display("FAIL bounce_busy_seen got=%b exp=1", busy_seen); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bounce_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_bouncy_press_release;
    int p0, p1;
    p0 = npulse;
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1; step(2);
      btn = 1'b0; step(1);
    end
    btn = 1'b1;
    step(10);
    total++;
    if (npulse - p0 !== 1) begin bad++; $display("FAIL bouncy_press_pulse got=%0d exp=1", npulse - p0); end
    total++;
    if (btn_stable !== 1'b1) begin bad++; $display("FAIL bouncy_stable_high got=%b exp=1", btn_stable); end
    p1 = npulse;
    for (int i = 0; i < 3; i++) begin
      btn = 1'b0; step(2);
      btn = 1'b1; step(1);
    end
    btn = 1'b0;
    step(6); // Y+5
    total++;
    if (btn_stable !== 1'b1) begin bad++; $display("FAIL release_y5 got=%b exp=1", btn_stable); end
    step(1); // Y+6
    total++;
    if (btn_stable !== 1'b0) begin bad++; $display("FAIL release_y6 got=%b exp=0", btn_stable); end
    step(4);
    total++;
    if (npulse - p1 !== 0) begin bad++; $display("FAIL release_no_pulse got=%0d exp=0", npulse - p1); end
  endtask

  task automatic test_reset_mid;
    int p0;
    btn = 1'b1;
    step(4); // X+3, in CNT_HIGH
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    total++;
    if ({t, btn_stable, busy} !== 3'b000) begin
      bad++; $display("FAIL rstmid_drop got=%b exp=000", {t, btn_stable, busy});
    end
    step(2);
    p0 = npulse;
    rst = 1'b0;
    step(6); // R+5
    total++;
    if (t !== 1'b0) begin bad++; $display("FAIL rstmid_r5 got=%b exp=0", t); end
    step(1); // R+6
    total++;
    if ({t, btn_stable} !== 2'b11) begin
      bad++; $display("FAIL rstmid_r6 got=%b exp=11", {t, btn_stable});
    end
    // Reset coinciding with the pulse cycle kills it at once
    rst = 1'b1;
    #1;
    total++;
    if (t !== 1'b0) begin bad++; $display("FAIL rst_during_t got=%b exp=0", t); end
    total++;
    if (npulse - p0 !== 0) begin bad++; $display("FAIL rst_during_t_count got=%0d exp=0", npulse - p0); end
    btn = 1'b0;
    step(2);
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_tff_integration;
    logic exp_q;
    exp_q = q;
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL tff_start got=%b exp=0", q); end
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1;
      step(7); // X+6, pulse cycle
      total++;
      if ({t, q} !== {1'b1, exp_q}) begin
        bad++; $display("FAIL tff_press%0d_x6 got=%b exp=%b", i, {t, q}, {1'b1, exp_q});
      end
      exp_q = ~exp_q;
      step(1); // X+7
      total++;
      if ({t, q} !== {1'b0, exp_q}) begin
        bad++; $display("FAIL tff_press%0d_x7 got=%b exp=%b", i, {t, q}, {1'b0, exp_q});
      end
      step(5);
      btn = 1'b0;
      step(10);
    end
    total++;
    if (q !== 1'b1) begin bad++; $display("FAIL tff_final got=%b exp=1", q); end
  endtask

  task automatic test_d1;
    int p0;
    p0 = npulse1;
    btn1 = 1'b1;
    step(2); // X+1
    btn1 = 1'b0;
    step(2); // X+3
    total++;
    if ({t1, btn_stable1} !== 2'b11) begin
      bad++; $display("FAIL d1_two_wide got=%b exp=11", {t1, btn_stable1});
    end
    step(6);
    total++;
    if (npulse1 - p0 !== 1) begin bad++; $display("FAIL d1_two_count got=%0d exp=1", npulse1 - p0); end
    total++;
    if ({btn_stable1, busy1} !== 2'b00) begin
      bad++; $display("FAIL d1_settled got=%b exp=00", {btn_stable1, busy1});
    end
    p0 = npulse1;
    btn1 = 1'b1;
    step(1);
    btn1 = 1'b0;
    step(8);
    total++;
    if (npulse1 - p0 !== 0) begin bad++; $display("FAIL d1_one_wide got=%0d exp=0", npulse1 - p0); end
    total++;
    if (btn_stable1 !== 1'b0) begin bad++; $display("FAIL d1_one_stable got=%b exp=0", btn_stable1); end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_short_bounce;
    test_bouncy_press_release;
    test_reset_mid;
    test_tff_integration;
    test_d1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
